map_row_fetcher: RTL
====================

# map_row_fetcher

Display-side reader of the map RAM. Once per VGA line it fetches the 160-bit map row that covers the line about to be drawn, through map RAM port A. Port B belongs to the sprite writer. It then serves one 4-bit tile code per pixel from a registered row buffer, together with the pixel's offset inside its tile, to the pixel colour stage. Tiles are 16x16 pixels, and the grid is 40 columns by 30 rows on a 640x480 frame.

## Interface
Parameters:
- RD_LAT, 2: CLOCK_50 cycles from a stable `rdaddr` to valid `redata`. Legal range 1..7.

Ports:
- CLOCK_50  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- line_req  in  1  one-cycle pulse issued in horizontal blanking, naming the next line to display.
- req_y  in  9  line number of the next line; sampled only when line_req=1.
- x  in  10  current pixel column.
- y  in  9  current pixel line.
- redata  in  160  map RAM port A read data (q_a).
- rdaddr  out  5  map RAM port A address.
- tile  out  4  tile code at (x,y), registered.
- sub_x  out  4  pixel column inside the tile, registered.
- sub_y  out  4  pixel line inside the tile, registered.
- busy  out  1  high while a fetch is in progress.
- fetch_done  out  1  one-cycle pulse on the cycle the row buffer loads.
- overrun  out  1  sticky; set when a line_req arrives while busy.

## Operation
- Row/column mapping: row = y[8:4], col = x[9:4].
- Nibble order: column c occupies redata[159-4c -: 4], i.e. column 0 is the most significant nibble. This matches the writer's packing.
- Fetch FSM has four states: IDLE, ADDR, WAIT, CAPTURE.
- IDLE: on line_req with req_y<480:
  - latch row_q = req_y[8:4];
  - drive rdaddr = row_q;
  - go to ADDR.
- IDLE, line_req with req_y>=480: no fetch; clear row_valid; stay in IDLE.
- ADDR: load wait counter with RD_LAT-1; go to WAIT. If RD_LAT=1, go straight to CAPTURE.
- WAIT: decrement the counter; go to CAPTURE when it reaches 0.
- CAPTURE:
  - load buf <= redata;
  - set row_valid = 1;
  - pulse fetch_done;
  - return to IDLE.
- rdaddr holds row_q from ADDR through CAPTURE inclusive. In IDLE it holds its last value.
- Every line refetches its row, even when the row is unchanged, so writer updates appear within one line.
- line_req while busy:
  - set overrun;
  - abandon the current fetch;
  - latch the new req_y;
  - go to ADDR. Latest request wins.
  - buf is not modified by the abandoned fetch.
- Pixel output, registered each cycle:
  - tile <= (row_valid && x<640 && y<480) ? buf nibble[col] : 4'd0;
  - sub_x <= x[3:0];
  - sub_y <= y[3:0].
- Pixel outputs do not check that y matches row_q. The display controller guarantees it by issuing line_req once per line.

## Timing
- Fetch latency: line_req at cycle t gives fetch_done and the buf load at cycle t+RD_LAT+1. With the default RD_LAT=2 that is t+3.
- Pixel latency: one cycle from (x,y) to tile/sub_x/sub_y.
- The upstream controller must issue line_req at least RD_LAT+2 cycles before the first active pixel. Horizontal blanking provides about 320 cycles.
- Reset values: FSM=IDLE, rdaddr=0, buf=0, row_valid=0, tile=0, sub_x=0, sub_y=0, busy=0, fetch_done=0, overrun=0.
- Reset mid-fetch drops the fetch entirely; buf stays 0.
- Simultaneous reset and line_req: reset wins.
- busy = (state != IDLE).
- overrun clears only on reset.

## Structure
- A shared package map_pkg holds:
  - MAP_COLS=40, MAP_ROWS=30, TILE_BITS=4, ROW_BITS=160, TILE_PX=16;
  - the tile-code enum (0 empty, 4 pacman, 5 ghost, …), which map_RAM_writer also imports.
- One sub-module, tile_mux: a combinational 160-to-4 nibble select indexed by a 6-bit column, returning 0 for col>=40. It is reusable by the writer.

## Test plan
- Reset, then line_req with req_y=0 and a map RAM model whose row 0 = 160'h1234…: fetch_done exactly 3 cycles later; rdaddr=0; x=0 gives tile=4'h1 one cycle later; x=16 gives 4'h2.
- req_y=479: rdaddr=29; x=639 gives the row-29 column-39 nibble (redata[3:0]); x=640 gives tile=0.
- req_y=480: no fetch; busy stays 0; tile=0 for every x.
- line_req with req_y=32, then again 1 cycle later with req_y=48:
  - overrun=1;
  - rdaddr ends at 3;
  - buf holds row 3, never row 2;
  - one fetch_done pulse.
- Writer changes row 5 column 7 from 0 to 4; next line_req with req_y=80: x=112 gives tile=4.
- Assert reset in the WAIT state: all outputs return to reset values next cycle; no fetch_done follows.

Source files
------------

// File: rtl/map_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : map_pkg
//  Description : Shared map geometry constants, tile codes and fetch states.
//  Revision    : 1.0 - initial release
// ============================================================================
package map_pkg;

    localparam int MAP_COLS  = 40;
    localparam int MAP_ROWS  = 30;
    localparam int TILE_BITS = 4;
    localparam int ROW_BITS  = 160;
    localparam int TILE_PX   = 16;
    localparam int COL_BITS  = 6;
    localparam int ROW_ABITS = 5;
    localparam int FRAME_W   = 640;
    localparam int FRAME_H   = 480;

    typedef enum logic [TILE_BITS-1:0] {
        TILE_EMPTY  = 4'd0,
        TILE_PACMAN = 4'd4,
        TILE_GHOST  = 4'd5
    } tile_code_e;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_ADDR    = 2'd1,
        FETCH_WAIT    = 2'd2,
        FETCH_CAPTURE = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/tile_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tile_mux
//  Description : Selects one tile nibble from a packed map row; column 0 is
//                the most significant nibble, columns past the map read 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_mux
    import map_pkg::*;
(
    input  logic [ROW_BITS-1:0]  row_i,
    input  logic [COL_BITS-1:0]  col_i,
    output logic [TILE_BITS-1:0] tile_o
);

    always_comb begin
        tile_o = '0;
        for (int c = 0; c < MAP_COLS; c++) begin
            if (col_i == COL_BITS'(c)) begin
                tile_o = row_i[ROW_BITS-1-TILE_BITS*c -: TILE_BITS];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/map_row_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : map_row_fetcher
//  Description : Fetches one map row per display line from map RAM port A and
//                serves registered per-pixel tile codes and in-tile offsets.
//  Revision    : 1.0 - initial release
// ============================================================================
module map_row_fetcher
    import map_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 line_req,
    input  logic [8:0]           req_y,
    input  logic [9:0]           x,
    input  logic [8:0]           y,
    input  logic [ROW_BITS-1:0]  redata,
    output logic [ROW_ABITS-1:0] rdaddr,
    output logic [TILE_BITS-1:0] tile,
    output logic [3:0]           sub_x,
    output logic [3:0]           sub_y,
    output logic                 busy,
    output logic                 fetch_done,
    output logic                 overrun
);

    localparam int CNT_W = 3;

    fetch_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ROW_ABITS-1:0]  row_q, row_d;
    logic [ROW_BITS-1:0]   buf_q, buf_d;
    logic                  row_valid_q, row_valid_d;
    logic                  overrun_q, overrun_d;
    logic [TILE_BITS-1:0]  tile_q;
    logic [3:0]            sub_x_q, sub_y_q;
    logic                  fetch_done_w;
    logic                  req_in_frame_w;
    logic [TILE_BITS-1:0]  mux_tile_w;
    logic                  w_unused_req_low;

    assign w_unused_req_low = &{1'b0, req_y[3:0]};
    assign req_in_frame_w   = (req_y < 9'(FRAME_H));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        row_d        = row_q;
        buf_d        = buf_q;
        row_valid_d  = row_valid_q;
        overrun_d    = overrun_q;
        fetch_done_w = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                if (line_req) begin
                    if (req_in_frame_w) begin
                        row_d   = req_y[8:4];
                        state_d = FETCH_ADDR;
                    end else begin
                        row_valid_d = 1'b0;
                    end
                end
            end
            FETCH_ADDR: begin
                if (RD_LAT == 1) begin
                    state_d = FETCH_CAPTURE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FETCH_CAPTURE;
                end
            end
            FETCH_CAPTURE: begin
                buf_d        = redata;
                row_valid_d  = 1'b1;
                fetch_done_w = 1'b1;
                state_d      = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase

        // A request during a fetch discards it outright, even in CAPTURE.
        if (line_req && (state_q != FETCH_IDLE)) begin
            overrun_d    = 1'b1;
            buf_d        = buf_q;
            row_valid_d  = row_valid_q;
            cnt_d        = cnt_q;
            fetch_done_w = 1'b0;
            if (req_in_frame_w) begin
                row_d   = req_y[8:4];
                state_d = FETCH_ADDR;
            end else begin
                row_valid_d = 1'b0;
                state_d     = FETCH_IDLE;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= FETCH_IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            buf_q       <= '0;
            row_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            buf_q       <= buf_d;
            row_valid_q <= row_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    tile_mux u_tile_mux (
        .row_i  (buf_q),
        .col_i  (x[9:4]),
        .tile_o (mux_tile_w)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tile_q  <= '0;
            sub_x_q <= '0;
            sub_y_q <= '0;
        end else begin
            tile_q  <= (row_valid_q && (x < 10'(FRAME_W)) && (y < 9'(FRAME_H)))
                       ? mux_tile_w : TILE_EMPTY;
            sub_x_q <= x[3:0];
            sub_y_q <= y[3:0];
        end
    end

    assign rdaddr     = row_q;
    assign tile       = tile_q;
    assign sub_x      = sub_x_q;
    assign sub_y      = sub_y_q;
    assign busy       = (state_q != FETCH_IDLE);
    assign fetch_done = fetch_done_w;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire
